// File: rtl/mat_vec_result_tx.sv
// mat_vec_result_tx
// Drains the matrix-vector MAC array results and streams them over a byte link.
// When `done` rises, all lane results are captured into shadow registers and sent
// little-endian, lane 0 first, over a valid/ready byte interface. After the final
// byte the block pulses `mac_clr` to clear the multiplier accumulators.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   done                : multiplier results-valid level (rising edge triggers a frame)
//   res_in[LANES-1:0]   : multiplier result bus, RES_WIDTH bits per lane
//   tx_data/valid/last  : byte stream towards the host (registered)
//   tx_ready            : sink accepts the offered byte
//   mac_clr             : one-cycle accumulator clear pulse (registered)
//   busy                : high while not idle (registered)
//   overrun             : sticky, set when a trigger arrives mid-frame (registered)
module mat_vec_result_tx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 8,
  parameter int unsigned RES_WIDTH  = 3 * DATA_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             done,
  input  logic [LANES-1:0][RES_WIDTH-1:0]  res_in,
  output logic [7:0]                       tx_data,
  output logic                             tx_valid,
  input  logic                             tx_ready,
  output logic                             tx_last,
  output logic                             mac_clr,
  output logic                             busy,
  output logic                             overrun
);

  localparam int unsigned BYTES  = RES_WIDTH / 8;
  localparam int unsigned LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t                          state_q, state_d;
  logic                            done_q;
  logic [LANES-1:0][RES_WIDTH-1:0] shadow_q, shadow_d;
  logic [LIDX_W-1:0]               lane_q, lane_d;
  logic [BIDX_W-1:0]               byte_q, byte_d;
  logic [7:0]                      tx_data_q, tx_data_d;
  logic                            tx_valid_q, tx_valid_d;
  logic                            tx_last_q, tx_last_d;
  logic                            mac_clr_q, mac_clr_d;
  logic                            busy_q, busy_d;
  logic                            overrun_q, overrun_d;

  logic                            trigger;
  logic [LIDX_W-1:0]               lane_nx;
  logic [BIDX_W-1:0]               byte_nx;
  logic [RES_WIDTH-1:0]            lane_word;

  assign trigger = done & ~done_q;

  // Index of the byte following the one currently offered
  always_comb begin
    lane_nx = lane_q;
    byte_nx = byte_q + BIDX_W'(1);
    if (byte_q == BIDX_W'(BYTES - 1)) begin
      byte_nx = '0;
      lane_nx = lane_q + LIDX_W'(1);
    end
    lane_word = shadow_q[lane_nx];
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    lane_d     = lane_q;
    byte_d     = byte_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    tx_last_d  = tx_last_q;
    mac_clr_d  = 1'b0;
    // A trigger while a frame is still in flight drops that new frame
    overrun_d  = overrun_q | (trigger & (state_q != S_IDLE));

    unique case (state_q)
      S_IDLE: begin
        if (trigger) begin
          shadow_d   = res_in;
          lane_d     = '0;
          byte_d     = '0;
          tx_data_d  = res_in[0][7:0];
          tx_valid_d = 1'b1;
          tx_last_d  = (LANES == 1) && (BYTES == 1);
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          if (tx_last_q) begin
            lane_d     = '0;
            byte_d     = '0;
            tx_data_d  = '0;
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
            mac_clr_d  = 1'b1;
            state_d    = S_CLEAR;
          end else begin
            lane_d    = lane_nx;
            byte_d    = byte_nx;
            tx_data_d = lane_word[{byte_nx, 3'b000} +: 8];
            tx_last_d = (lane_nx == LIDX_W'(LANES - 1)) &&
                        (byte_nx == BIDX_W'(BYTES - 1));
          end
        end
      end
      S_CLEAR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      done_q     <= 1'b0;
      shadow_q   <= '0;
      lane_q     <= '0;
      byte_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      mac_clr_q  <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= done;
      shadow_q   <= shadow_d;
      lane_q     <= lane_d;
      byte_q     <= byte_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
      mac_clr_q  <= mac_clr_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign tx_last  = tx_last_q;
  assign mac_clr  = mac_clr_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_mat_vec_result_tx.sv
// tb_mat_vec_result_tx
// Directed bench for mat_vec_result_tx: reset, basic frame, backpressure with
// input isolation, level done, overrun and mid-frame reset.
module tb_mat_vec_result_tx;

  logic             clk;
  logic             rst_n;
  logic             done;
  logic [7:0][23:0] res_in;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             tx_last;
  logic             mac_clr;
  logic             busy;
  logic             overrun;

  mat_vec_result_tx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .done     (done),
    .res_in   (res_in),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_last  (tx_last),
    .mac_clr  (mac_clr),
    .busy     (busy),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stream collector, sampled on the falling edge
  logic [7:0]  got_b[$];
  logic        got_l[$];
  int unsigned got_c[$];
  int unsigned cyc       = 0;
  int unsigned valid_cnt = 0;
  int unsigned busy_cnt  = 0;
  int unsigned clr_cnt   = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data  = 8'h00;
  logic        prev_last  = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (tx_valid) valid_cnt++;
      if (busy)     busy_cnt++;
      if (mac_clr)  clr_cnt++;
      if (prev_stall) begin
        check_eq("stall_valid", 32'(tx_valid), 32'd1);
        check_eq("stall_data",  32'(tx_data),  32'(prev_data));
        check_eq("stall_last",  32'(tx_last),  32'(prev_last));
      end
      if (tx_valid && tx_ready) begin
        got_b.push_back(tx_data);
        got_l.push_back(tx_last);
        got_c.push_back(cyc);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_last  = tx_last;
    end
  end

  logic [7:0] exp_b[24];

  task automatic clr_stats();
    got_b.delete();
    got_l.delete();
    got_c.delete();
    valid_cnt = 0;
    busy_cnt  = 0;
    clr_cnt   = 0;
  endtask

  task automatic set_res_a();
    for (int i = 0; i < 8; i++) res_in[i] = 24'hA0B0C0 + 24'(i);
    for (int i = 0; i < 8; i++) begin
      exp_b[3*i]   = 8'hC0 + 8'(i);
      exp_b[3*i+1] = 8'hB0;
      exp_b[3*i+2] = 8'hA0;
    end
  endtask

  task automatic set_res_b();
    for (int i = 0; i < 8; i++) res_in[i] = 24'h000100 * 24'(i);
    for (int i = 0; i < 8; i++) begin
      exp_b[3*i]   = 8'h00;
      exp_b[3*i+1] = 8'(i);
      exp_b[3*i+2] = 8'h00;
    end
  endtask

  task automatic check_frame(input string tag);
    check_eq({tag, "_count"}, 32'(got_b.size()), 32'd24);
    for (int i = 0; i < 24; i++) begin
      if (i < got_b.size()) begin
        check_eq($sformatf("%s_byte%0d", tag, i), 32'(got_b[i]), 32'(exp_b[i]));
        check_eq($sformatf("%s_last%0d", tag, i), 32'(got_l[i]), 32'(i == 23));
      end
    end
    check_eq({tag, "_clr"},  32'(clr_cnt), 32'd1);
    check_eq({tag, "_busy"}, 32'(busy),    32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_data"},    32'(tx_data),  32'd0);
    check_eq({tag, "_valid"},   32'(tx_valid), 32'd0);
    check_eq({tag, "_last"},    32'(tx_last),  32'd0);
    check_eq({tag, "_clr"},     32'(mac_clr),  32'd0);
    check_eq({tag, "_busy"},    32'(busy),     32'd0);
    check_eq({tag, "_overrun"}, 32'(overrun),  32'd0);
  endtask

  initial begin
    // Reset with random inputs
    rst_n    = 1'b0;
    done     = 1'b0;
    tx_ready = 1'b0;
    res_in   = '0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      done     = 1'($urandom_range(1, 0));
      tx_ready = 1'($urandom_range(1, 0));
      for (int i = 0; i < 8; i++) res_in[i] = 24'($urandom);
      #2;
      check_zero_outputs("reset");
    end
    done = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clr_stats();
    repeat (50) @(posedge clk);
    #1;
    check_eq("reset_idle_busy", 32'(busy_cnt), 32'd0);

    // Basic frame
    set_res_a();
    tx_ready = 1'b1;
    clr_stats();
    done = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_frame("basic");
    check_eq("basic_valid_cycles", 32'(valid_cnt), 32'd24);
    check_eq("basic_busy_cycles",  32'(busy_cnt),  32'd25);
    if (got_c.size() == 24)
      check_eq("basic_consecutive", 32'(got_c[23] - got_c[0]), 32'd23);
    done = 1'b0;
    repeat (5) @(posedge clk);

    // Backpressure and input isolation
    #1;
    clr_stats();
    done = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    for (int k = 0; k < 70; k++) begin
      @(posedge clk); #1;
      if (k == 0) for (int i = 0; i < 8; i++) res_in[i] = 24'hFFFFFF;
      tx_ready = ~tx_ready;
    end
    tx_ready = 1'b1;
    check_frame("bp");
    check_eq("bp_valid_cycles", 32'(valid_cnt), 32'd48);
    done = 1'b0;
    repeat (5) @(posedge clk);

    // Level done held for 200 cycles
    #1;
    set_res_a();
    clr_stats();
    done = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    check_frame("level");
    check_eq("level_overrun", 32'(overrun), 32'd0);
    done = 1'b0;
    repeat (5) @(posedge clk);

    // Overrun: retrigger during byte 5, new data must not leak
    #1;
    clr_stats();
    done = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    done = 1'b0;
    @(posedge clk); #1;
    done = 1'b1;
    for (int i = 0; i < 8; i++) res_in[i] = 24'hFFFFFF;
    repeat (100) @(posedge clk);
    #1;
    check_frame("ovr");
    check_eq("ovr_set", 32'(overrun), 32'd1);
    done = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_eq("ovr_sticky", 32'(overrun), 32'd1);

    // Reset mid-frame, then a fresh frame from lane 0 byte 0
    set_res_a();
    clr_stats();
    done = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_bytes_before", 32'(got_b.size()), 32'd10);
    check_zero_outputs("midrst");
    done = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    set_res_b();
    clr_stats();
    done = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_frame("post_rst");
    done = 1'b0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
